// File: rtl/ppu_raster_tracker_if.sv
// Port bundle for ppu_raster_tracker: raw PPU bus taps, channel config and raster outputs.
// The mapper core (or a bench) uses the master modport; the tracker uses slave.
interface ppu_raster_tracker_if #(
  parameter int CH = 2,
  parameter int SW = 1
);
  logic          ppu_oe;
  logic [13:0]   ppu_addr;
  logic          cfg_we;
  logic [SW-1:0] cfg_sel;
  logic [7:0]    cfg_line;
  logic          cfg_en;
  logic [CH-1:0] irq_ack;
  logic [5:0]    x_pos;
  logic [7:0]    y_pos;
  logic          in_frame;
  logic          line_stb;
  logic [CH-1:0] irq;
  logic [CH-1:0] chr_split;

  modport master (
    output ppu_oe, ppu_addr, cfg_we, cfg_sel, cfg_line, cfg_en, irq_ack,
    input  x_pos, y_pos, in_frame, line_stb, irq, chr_split
  );

  modport slave (
    input  ppu_oe, ppu_addr, cfg_we, cfg_sel, cfg_line, cfg_en, irq_ack,
    output x_pos, y_pos, in_frame, line_stb, irq, chr_split
  );
endinterface

// File: rtl/ppu_raster_tracker.sv
// Raster position tracker driven only by PPU fetch traffic, with CH sticky scanline-compare IRQs.
// Optional RASTER_CHR_SPLIT_EN builds per-channel registered CHR split levels.
module ppu_raster_tracker #(
  parameter int CH       = 2,
  parameter int IDLE_CYC = 96,
  parameter int SW       = 1
) (
  input logic                 clk,
  input logic                 map_rst,
  ppu_raster_tracker_if.slave bus
);
  localparam int IW = ($clog2(IDLE_CYC + 1) < 1) ? 1 : $clog2(IDLE_CYC + 1);
  localparam logic [IW-1:0] IDLE_LD = IW'(IDLE_CYC);

  logic            oe_s1_q, oe_s2_q, oe_prev_q;
  logic [13:0]     addr_s1_q, addr_s2_q;
  logic [IW-1:0]   idle_q, idle_d;
  logic [7:0]      nt_h_q, nt_h_d;
  logic            nt_vld_q, nt_vld_d;
  logic [5:0]      x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic            in_frame_q, in_frame_d;
  logic            spr_seen_q, spr_seen_d;
  logic            pre_q, pre_d;
  logic            stb_q, stb_d;
  logic [CH-1:0]   irq_q, irq_d;
  logic [CH-1:0][7:0] cmp_line_q, cmp_line_d;
  logic [CH-1:0]   cmp_en_q, cmp_en_d;

  logic vb, fetch, nt_bit, tile_step, line_end, hit_ev;

  // Stage p0: synchronizers; the address is data and carries no reset
  always_ff @(posedge clk) begin
    addr_s1_q <= bus.ppu_addr;
    addr_s2_q <= addr_s1_q;
  end

  always_comb begin
    idle_d = IDLE_LD;
    if (oe_s2_q) begin
      idle_d = (idle_q == '0) ? '0 : idle_q - IW'(1);
    end
    vb = (idle_d == '0);

    // A fall seen while the idle counter sits at 0 is swallowed with the vblank hold
    fetch  = oe_prev_q & ~oe_s2_q & (idle_q != '0);
    nt_bit = addr_s2_q[13] & ((addr_s2_q & 14'h23C0) != 14'h23C0);

    // Stage p1: NT history shift
    nt_h_d   = nt_h_q;
    nt_vld_d = 1'b0;
    if (fetch) begin
      nt_h_d   = {nt_h_q[6:0], nt_bit};
      nt_vld_d = 1'b1;
    end

    // Stage p2: pattern decode on the freshly shifted history
    tile_step = nt_vld_q & (nt_h_q[3:0] == 4'b1000);
    line_end  = nt_vld_q & (nt_h_q == 8'b1100_1100) & ~spr_seen_q;

    x_d        = x_q;
    y_d        = y_q;
    in_frame_d = in_frame_q;
    spr_seen_d = spr_seen_q;
    pre_d      = pre_q;
    stb_d      = 1'b0;
    hit_ev     = 1'b0;

    if (tile_step) begin
      x_d        = (x_q == 6'd63) ? x_q : x_q + 6'd1;
      spr_seen_d = 1'b0;
      in_frame_d = 1'b1;
    end

    if (line_end) begin
      spr_seen_d = 1'b1;
      x_d        = 6'd0;
      if (pre_q) begin
        pre_d = 1'b0;
      end else begin
        y_d    = (y_q == 8'd255) ? y_q : y_q + 8'd1;
        stb_d  = 1'b1;
        hit_ev = 1'b1;
      end
    end

    if (vb) begin
      x_d        = 6'd0;
      y_d        = 8'd0;
      pre_d      = 1'b1;
      in_frame_d = 1'b0;
      spr_seen_d = 1'b0;
      nt_h_d     = 8'd0;
      nt_vld_d   = 1'b0;
      stb_d      = 1'b0;
      hit_ev     = 1'b0;
    end

    // Priority per channel: config write over hit over ack
    irq_d      = irq_q;
    cmp_line_d = cmp_line_q;
    cmp_en_d   = cmp_en_q;
    for (int i = 0; i < CH; i++) begin
      if (bus.irq_ack[i]) begin
        irq_d[i] = 1'b0;
      end
      if (hit_ev && cmp_en_q[i] && (y_d == cmp_line_q[i])) begin
        irq_d[i] = 1'b1;
      end
      if (bus.cfg_we && (bus.cfg_sel == SW'(i))) begin
        cmp_line_d[i] = bus.cfg_line;
        cmp_en_d[i]   = bus.cfg_en;
        irq_d[i]      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      oe_s1_q    <= 1'b1;
      oe_s2_q    <= 1'b1;
      oe_prev_q  <= 1'b1;
      idle_q     <= '0;
      nt_h_q     <= 8'd0;
      nt_vld_q   <= 1'b0;
      x_q        <= 6'd0;
      y_q        <= 8'd0;
      in_frame_q <= 1'b0;
      spr_seen_q <= 1'b0;
      pre_q      <= 1'b1;
      stb_q      <= 1'b0;
      irq_q      <= '0;
      cmp_line_q <= '0;
      cmp_en_q   <= '0;
    end else begin
      oe_s1_q    <= bus.ppu_oe;
      oe_s2_q    <= oe_s1_q;
      oe_prev_q  <= oe_s2_q;
      idle_q     <= idle_d;
      nt_h_q     <= nt_h_d;
      nt_vld_q   <= nt_vld_d;
      x_q        <= x_d;
      y_q        <= y_d;
      in_frame_q <= in_frame_d;
      spr_seen_q <= spr_seen_d;
      pre_q      <= pre_d;
      stb_q      <= stb_d;
      irq_q      <= irq_d;
      cmp_line_q <= cmp_line_d;
      cmp_en_q   <= cmp_en_d;
    end
  end

  assign bus.x_pos    = x_q;
  assign bus.y_pos    = y_q;
  assign bus.in_frame = in_frame_q;
  assign bus.line_stb = stb_q;
  assign bus.irq      = irq_q;

`ifdef RASTER_CHR_SPLIT_EN
  logic [CH-1:0] split_q, split_d;

  // Stage p3: split levels trail y_pos by one cycle
  always_comb begin
    split_d = '0;
    if (!vb) begin
      for (int i = 0; i < CH; i++) begin
        split_d[i] = cmp_en_q[i] & in_frame_q & (y_q >= cmp_line_q[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      split_q <= '0;
    end else begin
      split_q <= split_d;
    end
  end

  assign bus.chr_split = split_q;
`else
  assign bus.chr_split = '0;
`endif

endmodule

// File: tb/tb_ppu_raster_tracker.sv
// Directed bench for ppu_raster_tracker: synthetic PPU fetch streams with hand-derived positions.
module tb_ppu_raster_tracker;
  localparam int CH   = 2;
  localparam int SW   = 1;
  localparam int IDLE = 20;

  logic clk = 1'b0;
  logic map_rst = 1'b1;
  always #5 clk = ~clk;

  ppu_raster_tracker_if #(.CH(CH), .SW(SW)) bus ();

  ppu_raster_tracker #(.CH(CH), .IDLE_CYC(IDLE), .SW(SW)) dut (
    .clk     (clk),
    .map_rst (map_rst),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int mid_x = 0;
  int end_x = 0;

  // Event monitor, sampled on the falling edge
  int stb_cnt = 0, stb_long = 0, irq0_rises = 0, irq0_at = -1, irq1_hi = 0;
  int split_hi = 0, split_rise_y = -1, split_rise_y1 = -1, split_rise_y2 = -1;
  logic stb_prev = 1'b0, irq0_prev = 1'b0, irq0_stb = 1'b0, split0_prev = 1'b0;
  int y1 = 0, y2 = 0;

  always @(negedge clk) begin
    if (bus.line_stb) stb_cnt = stb_cnt + 1;
    if (bus.line_stb && stb_prev) stb_long = stb_long + 1;
    if (bus.irq[0] && !irq0_prev) begin
      irq0_rises = irq0_rises + 1;
      irq0_at    = stb_cnt;
      irq0_stb   = bus.line_stb;
    end
    if (bus.irq[1]) irq1_hi = irq1_hi + 1;
    if (bus.chr_split != '0) split_hi = split_hi + 1;
    if (bus.chr_split[0] && !split0_prev && split_rise_y < 0) begin
      split_rise_y  = int'(bus.y_pos);
      split_rise_y1 = y1;
      split_rise_y2 = y2;
    end
    stb_prev    = bus.line_stb;
    irq0_prev   = bus.irq[0];
    split0_prev = bus.chr_split[0];
    y2 = y1;
    y1 = int'(bus.y_pos);
  end

  // ---------------- stimulus helpers ----------------
  task automatic fetch(input logic [13:0] a);
    bus.ppu_addr = a;
    bus.ppu_oe   = 1'b0;
    @(posedge clk); #1;
    bus.ppu_oe   = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic tile_grp(input int t);
    logic [13:0] tt;
    tt = 14'(t & 31);
    fetch(14'h2000 | tt);
    fetch(14'h23C0 | (tt >> 2));
    fetch(tt << 4);
    fetch((tt << 4) | 14'h0008);
  endtask

  task automatic spr_grp();
    fetch(14'h2000);
    fetch(14'h2000);
    fetch(14'h1000);
    fetch(14'h1008);
  endtask

  task automatic run_line(input int ntile, input int nspr);
    for (int t = 0; t < ntile; t++) tile_grp(t);
    spr_grp();
    mid_x = int'(bus.x_pos);
    for (int s = 1; s < nspr; s++) spr_grp();
    tile_grp(0);
    tile_grp(1);
    fetch(14'h2000);
    fetch(14'h2000);
    end_x = int'(bus.x_pos);
  endtask

  // Leaves the bench one edge before the line-end register update
  task automatic approach_line_end();
    tile_grp(0);
    tile_grp(1);
    spr_grp();
    spr_grp();
    @(posedge clk); #1;
  endtask

  task automatic finish_line();
    tile_grp(0);
    tile_grp(1);
    fetch(14'h2000);
    fetch(14'h2000);
  endtask

  task automatic cfg_write(input int sel, input int line, input logic en);
    bus.cfg_sel  = SW'(sel);
    bus.cfg_line = 8'(line);
    bus.cfg_en   = en;
    bus.cfg_we   = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.ppu_oe = 1'b1; bus.ppu_addr = 14'h0; bus.cfg_we = 1'b0;
    bus.cfg_sel = '0; bus.cfg_line = 8'd0; bus.cfg_en = 1'b0; bus.irq_ack = '0;
    map_rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    vectors++; if (bus.x_pos !== 6'd0) begin miscompares++; $display("FAIL reset_x: got %0d want 0", bus.x_pos); end
    vectors++; if (bus.y_pos !== 8'd0) begin miscompares++; $display("FAIL reset_y: got %0d want 0", bus.y_pos); end
    vectors++; if (bus.in_frame !== 1'b0) begin miscompares++; $display("FAIL reset_in_frame: got %0b want 0", bus.in_frame); end
    vectors++; if (bus.line_stb !== 1'b0) begin miscompares++; $display("FAIL reset_stb: got %0b want 0", bus.line_stb); end
    vectors++; if (bus.irq !== 2'b00) begin miscompares++; $display("FAIL reset_irq: got %b want 00", bus.irq); end
    vectors++; if (bus.chr_split !== 2'b00) begin miscompares++; $display("FAIL reset_split: got %b want 00", bus.chr_split); end
    map_rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_frame();
    int b_stb, b_long, b_irq, b_irq1;
    cfg_write(0, 128, 1'b1);
    cfg_write(1, 200, 1'b0);
    b_stb = stb_cnt; b_long = stb_long; b_irq = irq0_rises; b_irq1 = irq1_hi;
    run_line(32, 8);
    vectors++; if (end_x != 2) begin miscompares++; $display("FAIL pre_end_x: got %0d want 2", end_x); end
    vectors++; if (bus.y_pos !== 8'd0) begin miscompares++; $display("FAIL pre_y: got %0d want 0", bus.y_pos); end
    vectors++; if (stb_cnt - b_stb != 0) begin miscompares++; $display("FAIL pre_no_stb: got %0d want 0", stb_cnt - b_stb); end
    vectors++; if (bus.in_frame !== 1'b1) begin miscompares++; $display("FAIL pre_in_frame: got %0b want 1", bus.in_frame); end
    run_line(32, 8);
    vectors++; if (mid_x != 34) begin miscompares++; $display("FAIL line1_mid_x: got %0d want 34", mid_x); end
    vectors++; if (end_x != 2) begin miscompares++; $display("FAIL line1_end_x: got %0d want 2", end_x); end
    vectors++; if (bus.y_pos !== 8'd1) begin miscompares++; $display("FAIL line1_y: got %0d want 1", bus.y_pos); end
    for (int l = 2; l <= 240; l++) run_line(2, 2);
    vectors++; if (bus.y_pos !== 8'd240) begin miscompares++; $display("FAIL frame_y: got %0d want 240", bus.y_pos); end
    vectors++; if (stb_cnt - b_stb != 240) begin miscompares++; $display("FAIL frame_stb_count: got %0d want 240", stb_cnt - b_stb); end
    vectors++; if (stb_long - b_long != 0) begin miscompares++; $display("FAIL frame_stb_width: got %0d long pulses want 0", stb_long - b_long); end
    vectors++; if (irq0_rises - b_irq != 1) begin miscompares++; $display("FAIL irq0_rises: got %0d want 1", irq0_rises - b_irq); end
    vectors++; if (irq0_at - b_stb != 128) begin miscompares++; $display("FAIL irq0_line: got stb %0d want 128", irq0_at - b_stb); end
    vectors++; if (irq0_stb !== 1'b1) begin miscompares++; $display("FAIL irq0_with_stb: got %0b want 1", irq0_stb); end
    vectors++; if (irq1_hi - b_irq1 != 0) begin miscompares++; $display("FAIL irq1_disabled: got %0d cycles want 0", irq1_hi - b_irq1); end
    vectors++; if (bus.irq !== 2'b01) begin miscompares++; $display("FAIL frame_irq: got %b want 01", bus.irq); end
`ifdef RASTER_CHR_SPLIT_EN
    vectors++; if (split_rise_y != 128 || split_rise_y1 != 128 || split_rise_y2 != 127) begin
      miscompares++; $display("FAIL split_rise: got y=%0d/%0d/%0d want 128/128/127", split_rise_y, split_rise_y1, split_rise_y2);
    end
`else
    vectors++; if (split_hi != 0) begin miscompares++; $display("FAIL split_tied_off: got %0d high cycles want 0", split_hi); end
`endif
  endtask

  task automatic test_irq_ack();
    bus.irq_ack = 2'b01;
    @(posedge clk); #1;
    bus.irq_ack = 2'b00;
    vectors++; if (bus.irq[0] !== 1'b0) begin miscompares++; $display("FAIL ack_clears: got %0b want 0", bus.irq[0]); end
    cfg_write(0, 241, 1'b1);
    approach_line_end();
    bus.irq_ack = 2'b01;
    @(posedge clk); #1;
    bus.irq_ack = 2'b00;
    vectors++; if (bus.irq[0] !== 1'b1) begin miscompares++; $display("FAIL set_beats_ack: got %0b want 1", bus.irq[0]); end
    vectors++; if (bus.line_stb !== 1'b1) begin miscompares++; $display("FAIL hit_stb: got %0b want 1", bus.line_stb); end
    vectors++; if (bus.y_pos !== 8'd241) begin miscompares++; $display("FAIL hit_y: got %0d want 241", bus.y_pos); end
    @(posedge clk); #1;
    vectors++; if (bus.irq[0] !== 1'b1 || bus.line_stb !== 1'b0) begin
      miscompares++; $display("FAIL irq_sticky: got irq=%0b stb=%0b want 1 0", bus.irq[0], bus.line_stb);
    end
    finish_line();
    cfg_write(0, 242, 1'b1);
    vectors++; if (bus.irq[0] !== 1'b0) begin miscompares++; $display("FAIL cfg_clears: got %0b want 0", bus.irq[0]); end
    approach_line_end();
    bus.cfg_sel = 1'b0; bus.cfg_line = 8'd200; bus.cfg_en = 1'b1; bus.cfg_we = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    vectors++; if (bus.irq[0] !== 1'b0) begin miscompares++; $display("FAIL cfg_beats_hit: got %0b want 0", bus.irq[0]); end
    vectors++; if (bus.y_pos !== 8'd242) begin miscompares++; $display("FAIL cfg_hit_y: got %0d want 242", bus.y_pos); end
    finish_line();
  endtask

  task automatic test_vblank();
    int b_stb;
`ifdef RASTER_CHR_SPLIT_EN
    vectors++; if (bus.chr_split !== 2'b01) begin miscompares++; $display("FAIL split_before_vb: got %b want 01", bus.chr_split); end
`endif
    idle_cycles(IDLE - 2);
    vectors++; if (bus.y_pos !== 8'd242 || bus.in_frame !== 1'b1) begin
      miscompares++; $display("FAIL vb_early: got y=%0d in_frame=%0b want 242 1", bus.y_pos, bus.in_frame);
    end
    idle_cycles(3);
    vectors++; if (bus.y_pos !== 8'd0) begin miscompares++; $display("FAIL vb_y: got %0d want 0", bus.y_pos); end
    vectors++; if (bus.in_frame !== 1'b0) begin miscompares++; $display("FAIL vb_in_frame: got %0b want 0", bus.in_frame); end
    vectors++; if (bus.x_pos !== 6'd0) begin miscompares++; $display("FAIL vb_x: got %0d want 0", bus.x_pos); end
    vectors++; if (bus.chr_split !== 2'b00) begin miscompares++; $display("FAIL vb_split: got %b want 00", bus.chr_split); end
    b_stb = stb_cnt;
    run_line(32, 8);
    vectors++; if (stb_cnt - b_stb != 0 || bus.y_pos !== 8'd0) begin
      miscompares++; $display("FAIL vb_pre_render: got stb=%0d y=%0d want 0 0", stb_cnt - b_stb, bus.y_pos);
    end
    run_line(2, 2);
    vectors++; if (stb_cnt - b_stb != 1 || bus.y_pos !== 8'd1) begin
      miscompares++; $display("FAIL vb_first_line: got stb=%0d y=%0d want 1 1", stb_cnt - b_stb, bus.y_pos);
    end
  endtask

  task automatic test_map_rst();
    int b_stb;
    cfg_write(0, 40, 1'b1);
    idle_cycles(IDLE + 4);
    run_line(32, 8);
    for (int l = 1; l <= 50; l++) run_line(2, 2);
    vectors++; if (bus.y_pos !== 8'd50 || bus.irq[0] !== 1'b1) begin
      miscompares++; $display("FAIL rst_setup: got y=%0d irq0=%0b want 50 1", bus.y_pos, bus.irq[0]);
    end
    tile_grp(0); tile_grp(1); tile_grp(2);
    #2 map_rst = 1'b1;
    #1;
    vectors++; if (bus.x_pos !== 6'd0 || bus.y_pos !== 8'd0) begin
      miscompares++; $display("FAIL rst_pos: got x=%0d y=%0d want 0 0", bus.x_pos, bus.y_pos);
    end
    vectors++; if (bus.irq !== 2'b00 || bus.in_frame !== 1'b0 || bus.line_stb !== 1'b0 || bus.chr_split !== 2'b00) begin
      miscompares++; $display("FAIL rst_flags: got irq=%b in_frame=%0b stb=%0b split=%b want 00 0 0 00",
                              bus.irq, bus.in_frame, bus.line_stb, bus.chr_split);
    end
    @(posedge clk); @(posedge clk); #1;
    map_rst = 1'b0;
    b_stb = stb_cnt;
    run_line(32, 8);
    for (int l = 1; l <= 41; l++) run_line(2, 2);
    vectors++; if (bus.y_pos !== 8'd41 || stb_cnt - b_stb != 41) begin
      miscompares++; $display("FAIL rst_resume: got y=%0d stb=%0d want 41 41", bus.y_pos, stb_cnt - b_stb);
    end
    vectors++; if (bus.irq !== 2'b00) begin miscompares++; $display("FAIL rst_cfg_cleared: got irq=%b want 00", bus.irq); end
    vectors++; if (bus.in_frame !== 1'b1 || bus.chr_split !== 2'b00) begin
      miscompares++; $display("FAIL rst_resume_flags: got in_frame=%0b split=%b want 1 00", bus.in_frame, bus.chr_split);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_irq_ack();
    test_vblank();
    test_map_rst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end
endmodule
